tile_seq: RTL

Sequencer for the 8x8 systolic tile. It buffers an 8xK A operand and a Kx8 B operand written by the host, then streams them into the tile's row and column edges with the diagonal skew the array requires. It drives the tile enable and the accumulator clear, and reports completion. It sits between the host/DMA write port and the tile instance inside the accelerator top level.

---
 rtl/tile_seq_if.sv | 35 +++
 rtl/tile_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tile_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tile_seq_if
// Purpose  : Host write port and tile edge bundle for the 8x8 tile sequencer.
//            The master drives operand writes and START. The slave returns
//            status and the skewed row/column edge data.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface tile_seq_if #(
   parameter int KW = 3
);
   logic          WR_EN;
   logic          WR_SEL;
   logic [2:0]    WR_LANE;
   logic [KW-1:0] WR_K;
   logic [15:0]   WR_DATA;
   logic          START;
   logic          BUSY;
   logic          DONE;
   logic          CLR;
   logic          TILE_EN;
   logic [127:0]  ROW_OUT;
   logic [127:0]  COL_OUT;

   modport master (
      output WR_EN, WR_SEL, WR_LANE, WR_K, WR_DATA, START,
      input  BUSY, DONE, CLR, TILE_EN, ROW_OUT, COL_OUT
   );

   modport slave (
      input  WR_EN, WR_SEL, WR_LANE, WR_K, WR_DATA, START,
      output BUSY, DONE, CLR, TILE_EN, ROW_OUT, COL_OUT
   );
endinterface
`default_nettype wire

// File: rtl/tile_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tile_seq
// Purpose  : Buffers an 8xK A operand and a Kx8 B operand, then streams them
//            diagonally skewed into the 8x8 systolic tile edges. Drives the
//            accumulator clear and tile enable, and pulses DONE when the
//            tile results are final.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tile_seq #(
   parameter int K  = 8,
   parameter int KW = (K > 1) ? $clog2(K) : 1
) (
   input  logic       CLK,
   input  logic       RSTN,
   tile_seq_if.slave  bus
);
   // One run cycle per skew step: K data beats plus 7 row and 7 column skew
   // steps, plus one cycle for the last PE's registered MAC to settle.
   localparam int T  = K + 15;
   localparam int TW = $clog2(T);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            clr_q, clr_d;
   logic            en_q, en_d;
   logic [127:0]    row_q, row_d;
   logic [127:0]    col_q, col_d;

   // Operand storage is deliberately not reset; contents survive passes.
   logic [15:0]     a_q [8][K];
   logic [15:0]     b_q [K][8];

   logic            wr_ok;

   // Writes are only taken while idle and for an in-range reduction index.
   assign wr_ok = bus.WR_EN && !busy_q && ({1'b0, bus.WR_K} < (KW+1)'(K));

   // Operand array write port.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         if (!bus.WR_SEL) begin
            a_q[bus.WR_LANE][bus.WR_K] <= bus.WR_DATA;
         end else begin
            b_q[bus.WR_K][bus.WR_LANE] <= bus.WR_DATA;
         end
      end
   end

   // Pass sequencing: IDLE -> CLEAR -> RUN (T cycles) -> FIN -> IDLE.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
            t_d     = '0;
         end
         S_RUN: begin
            if (t_q == TW'(T - 1)) begin
               state_d = S_FIN;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in
   // the same cycle as the state they describe.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      clr_d  = (state_d == S_CLEAR);
      en_d   = (state_d == S_RUN);
      done_d = (state_d == S_FIN);
   end

   // Per-lane skew: lane g carries reduction index t-g when it is in range.
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic signed [TW+1:0] kr;
      logic [15:0]          row_v;
      logic [15:0]          col_v;

      // Select this lane's operand for the upcoming run cycle.
      always_comb begin
         kr    = $signed({2'b00, t_d}) - $signed((TW+2)'(gi));
         row_v = '0;
         col_v = '0;
         if ((state_d == S_RUN) && (kr >= 0) && (kr < $signed((TW+2)'(K)))) begin
            row_v = a_q[gi][kr[KW-1:0]];
            col_v = b_q[kr[KW-1:0]][gi];
         end
      end

      assign row_d[16*gi +: 16] = row_v;
      assign col_d[16*gi +: 16] = col_v;
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         en_q    <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         en_q    <= en_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign bus.BUSY    = busy_q;
   assign bus.DONE    = done_q;
   assign bus.CLR     = clr_q;
   assign bus.TILE_EN = en_q;
   assign bus.ROW_OUT = row_q;
   assign bus.COL_OUT = col_q;

endmodule
`default_nettype wire
